// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: width, operation codes, FSM encoding.
package mult_div_unit_pkg;
  localparam int LARGURA = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;
endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 32 bit-steps, pronto 33 cycles after accept.
// inicio and MTHI/MTLO are ignored while busy; no queueing.
module mult_div_unit #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [1:0]         operacao,
  input  logic [LARGURA-1:0] entradaA,
  input  logic [LARGURA-1:0] entradaB,
  input  logic               escreveHi,
  input  logic               escreveLo,
  output logic               ocupado,
  output logic               pronto,
  output logic               divZero,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo
);
  import mult_div_unit_pkg::*;

  estado_t                  state_q, state_d;
  logic [4:0]               cnt_q;
  logic [2*LARGURA-1:0]     acc_q;
  logic [LARGURA-1:0]       oper_q;
  logic                     mult_q, neg_q, rem_neg_q;
  logic [LARGURA-1:0]       hi_q, lo_q;
  logic                     pronto_q, pronto_d;
  logic                     divzero_q;

  logic                     aceita;
  logic                     com_sinal, eh_mult;
  logic [LARGURA-1:0]       mag_a, mag_b;
  logic [LARGURA:0]         soma, tentativa;
  logic [2*LARGURA-1:0]     acc_passo, produto;
  logic [LARGURA-1:0]       quociente, resto;

  assign aceita    = (state_q == OCIOSO) && inicio;
  assign com_sinal = ~operacao[0];
  assign eh_mult   = ~operacao[1];
  assign mag_a     = (com_sinal && entradaA[LARGURA-1]) ? -entradaA : entradaA;
  assign mag_b     = (com_sinal && entradaB[LARGURA-1]) ? -entradaB : entradaB;

  // Multiply: low half holds the multiplier, oper_q the multiplicand.
  // Divide: low half holds the dividend/quotient, high half the remainder, oper_q the divisor.
  assign soma      = {1'b0, acc_q[2*LARGURA-1:LARGURA]} + (acc_q[0] ? {1'b0, oper_q} : '0);
  assign tentativa = acc_q[2*LARGURA-1:LARGURA-1] - {1'b0, oper_q};
  assign acc_passo = mult_q ? {soma, acc_q[LARGURA-1:1]}
                   : tentativa[LARGURA] ? {acc_q[2*LARGURA-2:0], 1'b0}
                   : {tentativa[LARGURA-1:0], acc_q[LARGURA-2:0], 1'b1};

  assign produto   = neg_q ? -acc_q : acc_q;
  assign quociente = neg_q ? -acc_q[LARGURA-1:0] : acc_q[LARGURA-1:0];
  assign resto     = rem_neg_q ? -acc_q[2*LARGURA-1:LARGURA] : acc_q[2*LARGURA-1:LARGURA];

  always_ff @(posedge clock) begin
    if (!reset) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (inicio) state_d = CALCULA;
      CALCULA: if (cnt_q == 5'd31) state_d = FIM;
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado  = (state_q != OCIOSO);
    pronto_d = (state_q == FIM);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      oper_q    <= '0;
      mult_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pronto_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      pronto_q <= pronto_d;
      if (aceita) begin
        cnt_q     <= '0;
        mult_q    <= eh_mult;
        oper_q    <= eh_mult ? mag_a : mag_b;
        acc_q     <= {{LARGURA{1'b0}}, (eh_mult ? mag_b : mag_a)};
        neg_q     <= com_sinal && (entradaA[LARGURA-1] ^ entradaB[LARGURA-1]);
        rem_neg_q <= com_sinal && entradaA[LARGURA-1];
        divzero_q <= 1'b0;
      end else if (state_q == OCIOSO) begin
        if (escreveHi) hi_q <= entradaA;
        if (escreveLo) lo_q <= entradaA;
      end else if (state_q == CALCULA) begin
        cnt_q <= cnt_q + 5'd1;
        acc_q <= acc_passo;
      end else if (state_q == FIM) begin
        if (mult_q) begin
          hi_q <= produto[2*LARGURA-1:LARGURA];
          lo_q <= produto[LARGURA-1:0];
        end else if (oper_q == '0) begin
          divzero_q <= 1'b1;
        end else begin
          hi_q <= resto;
          lo_q <= quociente;
        end
      end
    end
  end

  assign pronto  = pronto_q;
  assign divZero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        inicio;
  logic [1:0]  operacao;
  logic [31:0] entradaA, entradaB;
  logic        escreveHi, escreveLo;
  logic        ocupado, pronto, divZero;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_dz = 1'b0;

  mult_div_unit #(.LARGURA(32)) dut (
    .clock(clock), .reset(reset), .inicio(inicio), .operacao(operacao),
    .entradaA(entradaA), .entradaB(entradaB),
    .escreveHi(escreveHi), .escreveLo(escreveLo),
    .ocupado(ocupado), .pronto(pronto), .divZero(divZero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, remainder takes dividend sign.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (!op[0]) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = $signed({32'b0, a});
      sb = $signed({32'b0, b});
    end
    exp_dz = 1'b0;
    if (!op[1]) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == 32'd0) begin
      exp_dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = q;
      exp_lo = p[31:0];
      p = r;
      exp_hi = p[31:0];
    end
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit interfere, input bit with_mtlo);
    logic [31:0] old_hi, old_lo;
    int n;
    old_hi = exp_hi;
    old_lo = exp_lo;
    model(op, a, b);
    operacao  = op;
    entradaA  = a;
    entradaB  = b;
    inicio    = 1'b1;
    escreveLo = with_mtlo;
    tick();
    inicio    = 1'b0;
    escreveLo = 1'b0;
    check({tag, ".busy"}, ocupado, 1'b1);
    check({tag, ".dzclr"}, divZero, 1'b0);
    check({tag, ".lo_hold"}, lo, old_lo);
    n = 0;
    while (!pronto && n < 40) begin
      inicio    = interfere && (n == 5);
      escreveHi = interfere && (n == 5);
      entradaA  = (interfere && n == 5) ? 32'hDEAD_BEEF : a;
      operacao  = (interfere && n == 5) ? ~op : op;
      tick();
      n++;
      if (n == 10) check({tag, ".hi_hold"}, hi, old_hi);
    end
    inicio    = 1'b0;
    escreveHi = 1'b0;
    check({tag, ".latency"}, n, 33);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
    check({tag, ".dz"}, divZero, exp_dz);
    check({tag, ".idle"}, ocupado, 1'b0);
    tick();
    check({tag, ".pulse"}, pronto, 1'b0);
  endtask

  initial begin
    bit saw_pronto;
    reset = 1'b0; inicio = 1'b0; operacao = '0; entradaA = '0; entradaB = '0;
    escreveHi = 1'b0; escreveLo = 1'b0;
    tick(); tick();
    check("rst.ocupado", ocupado, 1'b0);
    check("rst.pronto", pronto, 1'b0);
    check("rst.divZero", divZero, 1'b0);
    check("rst.hi", hi, 32'h0);
    check("rst.lo", lo, 32'h0);
    reset = 1'b1;
    tick();

    escreveHi = 1'b1; escreveLo = 1'b1; entradaA = 32'hA5A5_A5A5;
    tick();
    escreveHi = 1'b0; escreveLo = 1'b0;
    check("mthilo.hi", hi, 32'hA5A5_A5A5);
    check("mthilo.lo", lo, 32'hA5A5_A5A5);
    exp_hi = 32'hA5A5_A5A5; exp_lo = 32'hA5A5_A5A5;

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    check("mult_neg.hi_abs", hi, 32'hFFFF_FFFF);
    check("mult_neg.lo_abs", lo, 32'hFFFF_FFF1);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max.hi_abs", hi, 32'hFFFF_FFFE);
    check("multu_max.lo_abs", lo, 32'h0000_0001);
    run_op("div_neg7", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_neg7.lo_abs", lo, 32'hFFFF_FFFD);
    check("div_neg7.hi_abs", hi, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf.lo_abs", lo, 32'h8000_0000);
    check("div_ovf.hi_abs", hi, 32'h0);

    escreveHi = 1'b1; entradaA = 32'h11;
    tick();
    escreveHi = 1'b0; escreveLo = 1'b1; entradaA = 32'h22;
    tick();
    escreveLo = 1'b0;
    check("mthi.hi", hi, 32'h11);
    check("mtlo.lo", lo, 32'h22);
    exp_hi = 32'h11; exp_lo = 32'h22;
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu_zero.dz_abs", divZero, 1'b1);
    run_op("after_dz", 2'b01, 32'd6, 32'd7, 1'b0, 1'b0);

    run_op("busy_ign", 2'b00, 32'h1234_5678, 32'hFFFF_FF00, 1'b1, 1'b0);
    run_op("start_mtlo", 2'b11, 32'd1000, 32'd7, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, bit'($urandom_range(0, 1)), 1'b0);
    end

    escreveHi = 1'b1; escreveLo = 1'b1; entradaA = 32'h5;
    tick();
    escreveHi = 1'b0; escreveLo = 1'b0;
    operacao = 2'b00; entradaA = 32'd123; entradaB = 32'd456; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    tick();
    check("abort.ocupado", ocupado, 1'b0);
    check("abort.hi", hi, 32'h0);
    check("abort.lo", lo, 32'h0);
    check("abort.pronto", pronto, 1'b0);
    reset = 1'b1;
    saw_pronto = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pronto) saw_pronto = 1'b1;
    end
    check("abort.no_pulse", saw_pronto, 1'b0);
    check("abort.idle", ocupado, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter LARGURA, default 32, giving the operand/HI/LO width; only 32 is supported.
REQ-002 clock  input  1  the single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 inicio  input  1  start request, sampled only in state OCIOSO.
REQ-005 operacao  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with inicio.
REQ-006 entradaA  input  32  rs operand (multiplicand/dividend); also the data for escreveHi/escreveLo.
REQ-007 entradaB  input  32  rt operand (multiplier/divisor).
REQ-008 escreveHi, escreveLo  input  1 each  MTHI/MTLO write strobes.
REQ-009 ocupado  output  1  high whenever the state is not OCIOSO.
REQ-010 pronto  output  1  one-cycle pulse when the result is committed.
REQ-011 divZero  output  1  last DIV/DIVU had divisor 0.
REQ-012 hi, lo  output  32 each  HI/LO registers; they feed the writeback-select multiplexer (MFHI/MFLO).

Function
REQ-013 The FSM SHALL have states OCIOSO -> CALCULA -> FIM -> OCIOSO.
REQ-014 In OCIOSO with inicio=1, the block SHALL capture operacao, entradaA and entradaB, clear divZero, load the 5-bit counter with 0, and move to CALCULA.
REQ-015 CALCULA SHALL take exactly 32 cycles, one bit per cycle, and then move to FIM; with acceptance at edge T0, pronto is high in the cycle following edge T0+33.
REQ-016 MULT/MULTU SHALL use shift-add on magnitudes; {hi,lo} SHALL receive the 64-bit product.
REQ-017 DIV/DIVU SHALL use restoring division on magnitudes; lo SHALL receive the quotient and hi the remainder.
REQ-018 For signed operations, the block SHALL take magnitudes at capture and negate in FIM: the product sign is signA xor signB, the quotient sign is signA xor signB, and the remainder sign is signA.
REQ-019 0x80000000 / 0xFFFFFFFF (DIV) SHALL give lo=0x80000000, hi=0x00000000.
REQ-020 For a divisor of 0, the block SHALL still run the full latency; in FIM it SHALL leave hi/lo unchanged, set divZero=1 and pulse pronto.
REQ-021 In FIM, the block SHALL write hi/lo, set pronto=1 for exactly that cycle and return to OCIOSO.
REQ-022 The block SHALL ignore inicio while ocupado=1 (no queueing).
REQ-023 In OCIOSO without inicio, escreveHi SHALL load hi from entradaA and escreveLo SHALL load lo from entradaA; both may occur in the same cycle.
REQ-024 inicio SHALL have priority over escreveHi/escreveLo in the same cycle; the writes are dropped.
REQ-025 The block SHALL ignore escreveHi/escreveLo while ocupado=1.
REQ-026 hi/lo SHALL change only in FIM, on MTHI/MTLO, or at reset.
REQ-027 A new inicio SHALL be accepted in the cycle after FIM.

Reset
REQ-028 When reset=0 at a rising edge, the block SHALL return to OCIOSO and clear hi, lo, the counter and the internal registers to 0, and set pronto=0, ocupado=0 and divZero=0.
REQ-029 A reset during CALCULA or FIM SHALL abort the operation without a pronto pulse; hi/lo SHALL be 0 afterwards.

Structure
REQ-030 The shared package SHALL hold the operacao codes (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state encoding, and LARGURA=32.
REQ-031 The block SHALL be a single module with no sub-module; sign fix-up is inline.
REQ-032 The 64-bit accumulator/remainder register SHALL be private to the block; only hi and lo are visible.

Verification
REQ-033 MULT A=0xFFFFFFFD (-3), B=5 -> pronto 33 cycles after the accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 With hi=0x11, lo=0x22, DIVU 7/0 -> pronto pulses, divZero=1, hi=0x11, lo=0x22; the next inicio clears divZero.
REQ-037 inicio and escreveHi while busy -> both ignored; inicio+escreveLo in OCIOSO -> the operation starts and lo is not written.
REQ-038 reset=0 at cycle 10 of a MULT -> the next cycle shows ocupado=0, hi=lo=0, and no pronto pulse.
